// File: rtl/ptr_addr_unit_pkg.sv
// Shared definitions for the pointer/address unit: sequencer state encoding
// and the register-operation priority indices used by every pointer register.
package ptr_addr_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Op-vector bit positions, listed highest priority first.
    localparam int RO_CLR = 0;
    localparam int RO_WR  = 1;
    localparam int RO_INC = 2;
    localparam int RO_NUM = 3;

endpackage

// File: rtl/ptr_addr_unit_ptr_reg.sv
// One pointer register with its private limit register; an increment that
// hits the limit returns the pointer to zero and raises a one-cycle wrap pulse.
module ptr_reg
    import ptr_addr_unit_pkg::*;
#(
    parameter int AW = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [RO_NUM-1:0] op_i,
    input  logic              lim_wr_en_i,
    input  logic [AW-1:0]     wr_data_i,
    output logic [AW-1:0]     ptr_o,
    output logic              wrap_o
);

    logic [AW-1:0] ptr_q, ptr_d;
    logic [AW-1:0] lim_q, lim_d;
    logic          wrap_q, wrap_d;

    // Clear beats load beats increment; both increment sources arrive ORed into one bit.
    always_comb begin
        ptr_d  = ptr_q;
        wrap_d = 1'b0;
        lim_d  = lim_wr_en_i ? wr_data_i : lim_q;
        if (op_i[RO_CLR]) begin
            ptr_d = '0;
        end else if (op_i[RO_WR]) begin
            ptr_d = wr_data_i;
        end else if (op_i[RO_INC]) begin
            if (ptr_q == lim_q) begin
                ptr_d  = '0;
                wrap_d = 1'b1;
            end else begin
                ptr_d = ptr_q + AW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q  <= '0;
            lim_q  <= '1;
            wrap_q <= 1'b0;
        end else begin
            ptr_q  <= ptr_d;
            lim_q  <= lim_d;
            wrap_q <= wrap_d;
        end
    end

    assign ptr_o  = ptr_q;
    assign wrap_o = wrap_q;

endmodule

// File: rtl/ptr_addr_unit.sv
// Bank of NPTR pointer registers plus a small access sequencer that drives a
// data memory address from a selected pointer, with optional post-increment.
module ptr_addr_unit
    import ptr_addr_unit_pkg::*;
#(
    parameter int NPTR    = 4,
    parameter int AW      = 8,
    parameter int MEM_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NPTR-1:0]          clr_en,
    input  logic [NPTR-1:0]          wr_en,
    input  logic [NPTR-1:0]          lim_wr_en,
    input  logic [NPTR-1:0]          inc_en,
    input  logic [AW-1:0]            wr_data,
    input  logic                     req,
    input  logic [$clog2(NPTR)-1:0]  req_sel,
    input  logic                     req_we,
    input  logic                     req_pinc,
    output logic                     busy,
    output logic [AW-1:0]            addr,
    output logic                     mem_we,
    output logic                     rd_valid,
    output logic                     done,
    output logic                     err,
    output logic [NPTR-1:0]          wrap,
    output logic [NPTR*AW-1:0]       ptr_q
);

    localparam int SW = $clog2(NPTR);
    localparam int CW = 3;

    state_e          state_q, state_d;
    logic [SW-1:0]   sel_q, sel_d;
    logic            we_q, we_d;
    logic            pinc_q, pinc_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            err_q, err_d;

    logic [AW-1:0]   ptr_arr [NPTR];
    logic [AW-1:0]   sel_ptr;
    logic            sel_ok;
    logic            accept;
    logic            post_inc;

    assign sel_ok = ({1'b0, req_sel} < (SW+1)'(NPTR));
    assign accept = req && sel_ok && (state_q == ST_IDLE);

    always_comb begin
        sel_ptr = '0;
        for (int i = 0; i < NPTR; i++) begin
            if (req_sel == SW'(i)) sel_ptr = ptr_arr[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: if (accept) state_d = ST_ADDR;
            ST_ADDR: begin
                cnt_d   = '0;
                state_d = we_q ? ST_DONE : ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == CW'(MEM_LAT - 1)) state_d = ST_DONE;
                else                           cnt_d   = cnt_q + CW'(1);
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state_q != ST_IDLE);
        mem_we   = (state_q == ST_ADDR) && we_q;
        done     = (state_q == ST_DONE);
        rd_valid = (state_q == ST_DONE) && !we_q;
        post_inc = (state_q == ST_DONE) && pinc_q;
    end

    // Address is captured only at acceptance, so later pointer writes cannot disturb it.
    always_comb begin
        sel_d  = sel_q;
        we_d   = we_q;
        pinc_d = pinc_q;
        addr_d = addr_q;
        err_d  = req && !sel_ok && (state_q == ST_IDLE);
        if (accept) begin
            sel_d  = req_sel;
            we_d   = req_we;
            pinc_d = req_pinc;
            addr_d = sel_ptr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q  <= '0;
            we_q   <= 1'b0;
            pinc_q <= 1'b0;
            addr_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            sel_q  <= sel_d;
            we_q   <= we_d;
            pinc_q <= pinc_d;
            addr_q <= addr_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    assign addr = addr_q;
    assign err  = err_q;

    for (genvar i = 0; i < NPTR; i++) begin : g_ptr
        logic [RO_NUM-1:0] op;
        assign op[RO_CLR] = clr_en[i];
        assign op[RO_WR]  = wr_en[i];
        assign op[RO_INC] = inc_en[i] | (post_inc && (sel_q == SW'(i)));

        ptr_reg #(.AW(AW)) u_ptr (
            .clk         (clk),
            .rst         (rst),
            .op_i        (op),
            .lim_wr_en_i (lim_wr_en[i]),
            .wr_data_i   (wr_data),
            .ptr_o       (ptr_arr[i]),
            .wrap_o      (wrap[i])
        );

        assign ptr_q[i*AW +: AW] = ptr_arr[i];
    end

endmodule

// File: tb/tb_ptr_addr_unit.sv
// Directed bench for ptr_addr_unit with three pointers: a vector table walks
// reads, writes, wraps and errors; hand sequences cover reset and limit defaults.
module tb_ptr_addr_unit;

    localparam int NPTR    = 3;
    localparam int AW      = 8;
    localparam int MEM_LAT = 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [NPTR-1:0]   clr_en, wr_en, lim_wr_en, inc_en;
    logic [AW-1:0]     wr_data;
    logic              req;
    logic [1:0]        req_sel;
    logic              req_we, req_pinc;
    logic              busy, mem_we, rd_valid, done, err;
    logic [AW-1:0]     addr;
    logic [NPTR-1:0]   wrap;
    logic [NPTR*AW-1:0] ptr_q;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [2:0]  clr, wr, lim, inc;
        logic [7:0]  wdata;
        logic        rq;
        logic [1:0]  sel;
        logic        we, pinc;
        logic        eBusy, eMemWe, eDone, eRd, eErr;
        logic [2:0]  eWrap;
        logic [23:0] ePtr;
        logic [7:0]  eAddr;
    } vec_t;

    vec_t vq[$];

    ptr_addr_unit #(.NPTR(NPTR), .AW(AW), .MEM_LAT(MEM_LAT)) dut (
        .clk(clk), .rst(rst), .clr_en(clr_en), .wr_en(wr_en), .lim_wr_en(lim_wr_en),
        .inc_en(inc_en), .wr_data(wr_data), .req(req), .req_sel(req_sel),
        .req_we(req_we), .req_pinc(req_pinc), .busy(busy), .addr(addr),
        .mem_we(mem_we), .rd_valid(rd_valid), .done(done), .err(err),
        .wrap(wrap), .ptr_q(ptr_q)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        clr_en = '0; wr_en = '0; lim_wr_en = '0; inc_en = '0;
        wr_data = '0; req = 1'b0; req_sel = '0; req_we = 1'b0; req_pinc = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        clr_en = v.clr; wr_en = v.wr; lim_wr_en = v.lim; inc_en = v.inc;
        wr_data = v.wdata; req = v.rq; req_sel = v.sel;
        req_we = v.we; req_pinc = v.pinc;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic checkVec(input int k, input vec_t v);
        checkOutput($sformatf("v%0d busy", k),     32'(busy),     32'(v.eBusy));
        checkOutput($sformatf("v%0d mem_we", k),   32'(mem_we),   32'(v.eMemWe));
        checkOutput($sformatf("v%0d done", k),     32'(done),     32'(v.eDone));
        checkOutput($sformatf("v%0d rd_valid", k), 32'(rd_valid), 32'(v.eRd));
        checkOutput($sformatf("v%0d err", k),      32'(err),      32'(v.eErr));
        checkOutput($sformatf("v%0d wrap", k),     32'(wrap),     32'(v.eWrap));
        checkOutput($sformatf("v%0d ptr_q", k),    32'(ptr_q),    32'(v.ePtr));
        checkOutput($sformatf("v%0d addr", k),     32'(addr),     32'(v.eAddr));
    endtask

    initial begin
        // Each row: inputs held for one cycle, expected outputs seen in the next cycle.
        //            clr    wr     lim    inc    wdata  rq sel we pi  bsy mwe dn rd er wrap   ptr_q       addr
        vq.push_back('{3'b000,3'b010,3'b000,3'b000,8'h0A,0,2'd0,0,0, 0,0,0,0,0,3'b000,24'h000A00,8'h00});
        vq.push_back('{3'b000,3'b000,3'b000,3'b000,8'h00,1,2'd1,0,0, 1,0,0,0,0,3'b000,24'h000A00,8'h0A});
        vq.push_back('{3'b000,3'b000,3'b000,3'b000,8'h00,0,2'd0,0,0, 1,0,0,0,0,3'b000,24'h000A00,8'h0A});
        vq.push_back('{3'b000,3'b000,3'b000,3'b000,8'h00,0,2'd0,0,0, 1,0,1,1,0,3'b000,24'h000A00,8'h0A});
        vq.push_back('{3'b000,3'b000,3'b000,3'b000,8'h00,0,2'd0,0,0, 0,0,0,0,0,3'b000,24'h000A00,8'h0A});
        vq.push_back('{3'b000,3'b001,3'b001,3'b000,8'h03,0,2'd0,0,0, 0,0,0,0,0,3'b000,24'h000A03,8'h0A});
        vq.push_back('{3'b000,3'b000,3'b000,3'b000,8'h00,1,2'd0,1,1, 1,1,0,0,0,3'b000,24'h000A03,8'h03});
        vq.push_back('{3'b000,3'b000,3'b000,3'b000,8'h00,0,2'd0,0,0, 1,0,1,0,0,3'b000,24'h000A03,8'h03});
        vq.push_back('{3'b000,3'b000,3'b000,3'b000,8'h00,0,2'd0,0,0, 0,0,0,0,0,3'b001,24'h000A00,8'h03});
        vq.push_back('{3'b000,3'b000,3'b000,3'b000,8'h00,0,2'd0,0,0, 0,0,0,0,0,3'b000,24'h000A00,8'h03});
        vq.push_back('{3'b000,3'b100,3'b000,3'b000,8'h05,0,2'd0,0,0, 0,0,0,0,0,3'b000,24'h050A00,8'h03});
        vq.push_back('{3'b000,3'b000,3'b000,3'b000,8'h00,1,2'd2,0,1, 1,0,0,0,0,3'b000,24'h050A00,8'h05});
        vq.push_back('{3'b010,3'b000,3'b000,3'b000,8'h00,1,2'd0,1,1, 1,0,0,0,0,3'b000,24'h050000,8'h05});
        vq.push_back('{3'b000,3'b000,3'b000,3'b000,8'h00,0,2'd0,0,0, 1,0,1,1,0,3'b000,24'h050000,8'h05});
        vq.push_back('{3'b000,3'b000,3'b000,3'b100,8'h00,0,2'd0,0,0, 0,0,0,0,0,3'b000,24'h060000,8'h05});
        vq.push_back('{3'b000,3'b000,3'b000,3'b000,8'h00,1,2'd3,0,0, 0,0,0,0,1,3'b000,24'h060000,8'h05});
        vq.push_back('{3'b000,3'b000,3'b000,3'b000,8'h00,0,2'd0,0,0, 0,0,0,0,0,3'b000,24'h060000,8'h05});

        clearInputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        checkOutput("reset ptr_q", 32'(ptr_q), 32'h0);
        checkOutput("reset busy", 32'(busy), 32'h0);
        checkOutput("reset outs", 32'({mem_we, rd_valid, done, err, wrap}), 32'h0);
        checkOutput("reset addr", 32'(addr), 32'h0);

        for (int k = 0; k < vq.size(); k++) begin
            applyStimulus(vq[k]);
            tick();
            checkVec(k, vq[k]);
        end
        clearInputs();

        // Reset during WAIT of a post-increment read: abort at once, no late completion.
        req = 1'b1; req_sel = 2'd0; req_we = 1'b0; req_pinc = 1'b1;
        tick();
        clearInputs();
        tick();
        checkOutput("wait busy", 32'(busy), 32'h1);
        #2 rst = 1'b1;
        #1;
        checkOutput("async rst busy", 32'(busy), 32'h0);
        checkOutput("async rst ptr_q", 32'(ptr_q), 32'h0);
        tick();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            checkOutput($sformatf("abort done c%0d", c), 32'({done, rd_valid, busy}), 32'h0);
            checkOutput($sformatf("abort ptr_q c%0d", c), 32'(ptr_q), 32'h0);
        end

        // Limit resets to all-ones: FE -> FF is plain, FF -> 00 wraps.
        wr_en = 3'b001; wr_data = 8'hFE;
        tick();
        wr_en = '0; inc_en = 3'b001;
        tick();
        checkOutput("lim ptr FF", 32'(ptr_q), 32'h0000FF);
        checkOutput("lim no wrap", 32'(wrap), 32'h0);
        tick();
        inc_en = '0;
        checkOutput("lim ptr 00", 32'(ptr_q), 32'h000000);
        checkOutput("lim wrap", 32'(wrap), 32'h1);
        tick();
        checkOutput("lim wrap clear", 32'(wrap), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
